vga_timing_gen: RTL and testbench

- Parametrised VGA raster timing generator and pixel output stage. It is the successor to the fixed 640x480 timing block.
- Emits pixel requests (x, y, valid) to an upstream pixel source with a fixed read latency. It delays sync and blanking by the same latency so colour data lines up with timing.
- Drives the board VGA DAC pins directly. Supports any mode, either sync polarity and a pixel-clock enable.

---
 rtl/vga_timing_gen_if.sv | 31 +++
 rtl/vga_timing_gen.sv | 142 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Pixel request bus between the raster timing generator and the upstream
// pixel source.
//   req_x, req_y   : requested column/row (CW bits)
//   req_valid      : request lies in the active area
//   frame_start    : request is pixel (0,0)
//   line_start     : request is column 0 of a visible line
//   R, G, B        : colour returned by the source, a fixed number of
//                    enabled cycles after the request
// master = timing generator, slave = pixel source.
interface vga_timing_gen_if #(
   parameter int CW = 11
);
   logic [CW-1:0] req_x;
   logic [CW-1:0] req_y;
   logic          req_valid;
   logic          frame_start;
   logic          line_start;
   logic [7:0]    R;
   logic [7:0]    G;
   logic [7:0]    B;

   modport master (
      output req_x, req_y, req_valid, frame_start, line_start,
      input  R, G, B
   );

   modport slave (
      input  req_x, req_y, req_valid, frame_start, line_start,
      output R, G, B
   );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator and pixel output stage.
// Ports:
//   clk, rst_n     : pixel/system clock, async active-low reset
//   en             : pixel clock enable; every register holds while low
//   pix            : request bus to the pixel source (master side)
//   VGA_R/G/B      : registered colour, zero while blanked
//   VGA_HS/VS      : syncs, delayed to line up with the returned colour
//   VGA_BLANK_N    : high during active video, same alignment
//   VGA_SYNC_N     : constant 0, no sync-on-green
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FRONT  = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BACK   = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FRONT  = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BACK   = 33,
   parameter int HS_POL   = 0,
   parameter int VS_POL   = 0,
   parameter int PIX_LAT  = 2,
   parameter int CW       = 11
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   vga_timing_gen_if.master     pix,
   output logic [7:0]           VGA_R,
   output logic [7:0]           VGA_G,
   output logic [7:0]           VGA_B,
   output logic                 VGA_HS,
   output logic                 VGA_VS,
   output logic                 VGA_BLANK_N,
   output logic                 VGA_SYNC_N
);
   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_BEGIN = CW'(H_ACTIVE + H_FRONT);
   localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [CW-1:0] VS_BEGIN = CW'(V_ACTIVE + V_FRONT);
   localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FRONT + V_SYNC);

   localparam logic HS_ON   = (HS_POL != 0);
   localparam logic VS_ON   = (VS_POL != 0);
   localparam logic HS_IDLE = ~HS_ON;
   localparam logic VS_IDLE = ~VS_ON;

   logic [CW-1:0] h_cnt;
   logic [CW-1:0] v_cnt;
   logic          hs_raw;
   logic          vs_raw;
   logic          de_raw;
   logic          hs_d;
   logic          vs_d;
   logic          de_d;

   // Reset parks the raster on the last back-porch pixel so the first
   // enabled edge lands exactly on (0,0).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt <= H_LAST;
         v_cnt <= V_LAST;
      end else if (en) begin
         if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end
      end
   end

   assign de_raw = (h_cnt < H_ACT) && (v_cnt < V_ACT);
   assign hs_raw = ((h_cnt >= HS_BEGIN) && (h_cnt < HS_END)) ? HS_ON : HS_IDLE;
   assign vs_raw = ((v_cnt >= VS_BEGIN) && (v_cnt < VS_END)) ? VS_ON : VS_IDLE;

   assign pix.req_x       = h_cnt;
   assign pix.req_y       = v_cnt;
   assign pix.req_valid   = de_raw;
   assign pix.frame_start = (h_cnt == '0) && (v_cnt == '0);
   assign pix.line_start  = (h_cnt == '0) && (v_cnt < V_ACT);

   // Timing delay matching the source read latency; flushed to blanked
   // with idle syncs so nothing half-formed leaves after a reset.
   generate
      if (PIX_LAT == 0) begin : g_direct
         assign hs_d = hs_raw;
         assign vs_d = vs_raw;
         assign de_d = de_raw;
      end else begin : g_delay
         logic [PIX_LAT-1:0] hs_sr;
         logic [PIX_LAT-1:0] vs_sr;
         logic [PIX_LAT-1:0] de_sr;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               hs_sr <= {PIX_LAT{HS_IDLE}};
               vs_sr <= {PIX_LAT{VS_IDLE}};
               de_sr <= '0;
            end else if (en) begin
               hs_sr[0] <= hs_raw;
               vs_sr[0] <= vs_raw;
               de_sr[0] <= de_raw;
               for (int i = 1; i < PIX_LAT; i++) begin
                  hs_sr[i] <= hs_sr[i-1];
                  vs_sr[i] <= vs_sr[i-1];
                  de_sr[i] <= de_sr[i-1];
               end
            end
         end

         assign hs_d = hs_sr[PIX_LAT-1];
         assign vs_d = vs_sr[PIX_LAT-1];
         assign de_d = de_sr[PIX_LAT-1];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         VGA_R       <= '0;
         VGA_G       <= '0;
         VGA_B       <= '0;
         VGA_HS      <= HS_IDLE;
         VGA_VS      <= VS_IDLE;
         VGA_BLANK_N <= 1'b0;
      end else if (en) begin
         VGA_R       <= de_d ? pix.R : 8'h00;
         VGA_G       <= de_d ? pix.G : 8'h00;
         VGA_B       <= de_d ? pix.B : 8'h00;
         VGA_HS      <= hs_d;
         VGA_VS      <= vs_d;
         VGA_BLANK_N <= de_d;
      end
   end

   assign VGA_SYNC_N = 1'b0;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Two tiny-mode instances (8/2/2/2 x 4/1/1/1, 14 x 7 raster):
//   dut_a : active-high syncs, PIX_LAT=0, source R/G = req_x/req_y directly
//   dut_b : active-low syncs,  PIX_LAT=2, source R/G delayed 2 enabled cycles
// Expected values come from the count n of enabled edges since reset.
module tb_vga_timing_gen;
   localparam int CW = 8;

   logic clk = 1'b0;
   logic rst_n;
   logic en;
   always #5 clk = ~clk;

   vga_timing_gen_if #(.CW(CW)) a_if ();
   vga_timing_gen_if #(.CW(CW)) b_if ();

   logic [7:0] a_r, a_g, a_b, b_r, b_g, b_b;
   logic       a_hs, a_vs, a_bn, a_sn, b_hs, b_vs, b_bn, b_sn;

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
      .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
      .HS_POL(1), .VS_POL(1), .PIX_LAT(0), .CW(CW)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .en(en), .pix(a_if),
      .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b),
      .VGA_HS(a_hs), .VGA_VS(a_vs), .VGA_BLANK_N(a_bn), .VGA_SYNC_N(a_sn)
   );

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
      .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
      .HS_POL(0), .VS_POL(0), .PIX_LAT(2), .CW(CW)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en), .pix(b_if),
      .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b),
      .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_BLANK_N(b_bn), .VGA_SYNC_N(b_sn)
   );

   // Pixel sources
   assign a_if.R = a_if.req_x[7:0];
   assign a_if.G = a_if.req_y[7:0];
   assign a_if.B = 8'h3C;

   logic [7:0] sx1, sx2, sy1, sy2;
   always @(posedge clk) begin
      if (en) begin
         sx1 <= b_if.req_x[7:0];
         sx2 <= sx1;
         sy1 <= b_if.req_y[7:0];
         sy2 <= sy1;
      end
   end
   assign b_if.R = sx2;
   assign b_if.G = sy2;
   assign b_if.B = 8'hFF;

   int n;
   int n_checks;
   int n_fail;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s n=%0d: observed %0h expected %0h", tag, n, obs, exp);
      end
   endtask

   task automatic check_req();
      int l, x, y;
      l = (n + 97) % 98;
      x = l % 14;
      y = l / 14;
      chk("req_x", 16'(a_if.req_x), 16'(x));
      chk("req_y", 16'(a_if.req_y), 16'(y));
      chk("req_valid", 16'(a_if.req_valid), 16'((x < 8) && (y < 4)));
      chk("frame_start", 16'(a_if.frame_start), 16'((x == 0) && (y == 0)));
      chk("line_start", 16'(b_if.line_start), 16'((x == 0) && (y < 4)));
   endtask

   task automatic check_pins(input string pfx, input int lat, input logic pol,
                             input logic hs, input logic vs, input logic bn,
                             input logic sn, input logic [7:0] r,
                             input logic [7:0] g, input logic [7:0] b,
                             input logic [7:0] b_on);
      int p, px, py;
      logic ehs, evs, ede;
      if (n <= lat) begin
         ehs = ~pol; evs = ~pol; ede = 1'b0; px = 0; py = 0;
      end else begin
         p   = (n + 96 - lat) % 98;
         px  = p % 14;
         py  = p / 14;
         ehs = (px >= 10 && px <= 11) ? pol : ~pol;
         evs = (py == 5) ? pol : ~pol;
         ede = (px < 8) && (py < 4);
      end
      chk({pfx, "_hs"}, 16'(hs), 16'(ehs));
      chk({pfx, "_vs"}, 16'(vs), 16'(evs));
      chk({pfx, "_blank_n"}, 16'(bn), 16'(ede));
      chk({pfx, "_sync_n"}, 16'(sn), 16'h0);
      chk({pfx, "_r"}, 16'(r), ede ? 16'(px) : 16'h0);
      chk({pfx, "_g"}, 16'(g), ede ? 16'(py) : 16'h0);
      chk({pfx, "_b"}, 16'(b), ede ? 16'(b_on) : 16'h0);
   endtask

   task automatic check_all();
      check_req();
      check_pins("a", 0, 1'b1, a_hs, a_vs, a_bn, a_sn, a_r, a_g, a_b, 8'h3C);
      check_pins("b", 2, 1'b0, b_hs, b_vs, b_bn, b_sn, b_r, b_g, b_b, 8'hFF);
   endtask

   task automatic step(input logic e);
      en = e;
      @(posedge clk);
      if (e) n++;
      @(negedge clk);
      check_all();
   endtask

   initial begin
      int p;
      bit found;
      n = 0; n_checks = 0; n_fail = 0;
      rst_n = 1'b0;
      en = 1'b1;
      repeat (3) @(negedge clk);
      check_all();

      rst_n = 1'b1;
      repeat (200) step(1'b1);

      for (int i = 0; i < 120; i++) step((i % 2) == 0);

      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         step(1'b1);
         p = (n + 96) % 98;
         if ((p % 14) >= 10 && (p % 14) <= 11) found = 1'b1;
      end
      chk("hs_active_before_reset", 16'(a_hs), 16'h1);

      #2 rst_n = 1'b0;
      #1;
      n = 0;
      chk("async_rst_a_hs", 16'(a_hs), 16'h0);
      chk("async_rst_a_blank_n", 16'(a_bn), 16'h0);
      chk("async_rst_b_hs", 16'(b_hs), 16'h1);
      chk("async_rst_req_x", 16'(a_if.req_x), 16'd13);
      chk("async_rst_req_valid", 16'(a_if.req_valid), 16'h0);
      @(negedge clk);
      check_all();
      rst_n = 1'b1;
      repeat (40) step(1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
